// File: rtl/gpu_mem_arbiter_if.sv
// gpu_mem_arbiter_if: requester-side and memory-side handshake buses of gpu_mem_arbiter.
interface gpu_mem_arbiter_if #(
   parameter int N_REQ      = 4,
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 8
);
   logic [N_REQ-1:0]            r_req_vld, r_req_rdy, r_rsp_vld, r_rsp_rdy;
   logic [N_REQ*ADDR_WIDTH-1:0] r_req_addr;
   logic [DATA_WIDTH-1:0]       r_rsp_data, m_rsp_data;
   logic [ADDR_WIDTH-1:0]       m_req_addr;
   logic                        m_req_vld, m_req_rdy, m_rsp_vld, m_rsp_rdy;
   modport slave (
      input  r_req_vld, r_req_addr, r_rsp_rdy, m_req_rdy, m_rsp_vld, m_rsp_data,
      output r_req_rdy, r_rsp_vld, r_rsp_data, m_req_vld, m_req_addr, m_rsp_rdy
   );
   modport master (
      output r_req_vld, r_req_addr, r_rsp_rdy, m_req_rdy, m_rsp_vld, m_rsp_data,
      input  r_req_rdy, r_rsp_vld, r_rsp_data, m_req_vld, m_req_addr, m_rsp_rdy
   );
endinterface

// File: rtl/gpu_mem_arbiter.sv
// gpu_mem_arbiter: round-robin sharing of one memory port among N_REQ fetch requesters;
// responses are routed back through an in-order owner-ID FIFO.
module gpu_mem_arbiter #(
   parameter int N_REQ      = 4,
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 8,
   parameter int MAX_OUTST  = 2
) (
   input  logic                        clk,
   input  logic                        rst_n,
   gpu_mem_arbiter_if.slave            bus,
   output logic [$clog2(MAX_OUTST):0]  outstanding,
   output logic                        busy,
   output logic                        err_unexp
);
   localparam int IW = $clog2(N_REQ);
   localparam int PW = MAX_OUTST > 1 ? $clog2(MAX_OUTST) : 1;
   localparam int OW = $clog2(MAX_OUTST) + 1;
   logic [IW-1:0] rr_ptr, locked_id, winner, head_id;
   logic [IW-1:0] ids [MAX_OUTST];
   logic [PW-1:0] head, tail;
   logic          lock, have_win, full, empty, push, pop;
   // Scan downwards so the requester closest to rr_ptr is assigned last and wins.
   always_comb begin
      winner   = locked_id;
      have_win = lock;
      if (!lock)
         for (int k = N_REQ - 1; k >= 0; k--)
            if (bus.r_req_vld[(int'(rr_ptr) + k) % N_REQ]) begin
               winner   = IW'((int'(rr_ptr) + k) % N_REQ);
               have_win = 1'b1;
            end
   end
   assign full           = outstanding == OW'(MAX_OUTST);
   assign empty          = outstanding == '0;
   assign head_id        = ids[head];
   assign bus.m_req_vld  = rst_n && have_win && !full && bus.r_req_vld[winner];
   assign bus.m_req_addr = have_win ? bus.r_req_addr[int'(winner)*ADDR_WIDTH +: ADDR_WIDTH] : '0;
   assign bus.r_req_rdy  = (rst_n && have_win && bus.m_req_rdy && !full) ? N_REQ'(1) << winner : '0;
   assign bus.r_rsp_vld  = (bus.m_rsp_vld && !empty) ? N_REQ'(1) << head_id : '0;
   assign bus.m_rsp_rdy  = !empty && bus.r_rsp_rdy[head_id];
   assign bus.r_rsp_data = bus.m_rsp_data;
   assign push           = bus.m_req_vld && bus.m_req_rdy;
   assign pop            = bus.m_rsp_vld && bus.m_rsp_rdy;
   assign busy           = !empty || |bus.r_req_vld;
   always_ff @(posedge clk)
      if (push) ids[tail] <= winner;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         rr_ptr      <= '0;
         lock        <= 1'b0;
         locked_id   <= '0;
         head        <= '0;
         tail        <= '0;
         outstanding <= '0;
         err_unexp   <= 1'b0;
      end else begin
         if (push) begin
            rr_ptr <= IW'((int'(winner) + 1) % N_REQ);
            lock   <= 1'b0;
            tail   <= (tail == PW'(MAX_OUTST - 1)) ? '0 : tail + 1'b1;
         end else if (bus.m_req_vld) begin
            lock      <= 1'b1;
            locked_id <= winner;
         end
         if (pop) head <= (head == PW'(MAX_OUTST - 1)) ? '0 : head + 1'b1;
         if (push != pop) outstanding <= push ? outstanding + 1'b1 : outstanding - 1'b1;
         if (empty && bus.m_rsp_vld) err_unexp <= 1'b1;
      end
endmodule

// File: tb/tb_gpu_mem_arbiter.sv
// tb_gpu_mem_arbiter: directed checks of gpu_mem_arbiter against a 1-cycle memory model;
// expected owner/data pairs queue up at each grant and are matched as responses return.
module tb_gpu_mem_arbiter;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [1:0] outstanding;
   logic       busy, err_unexp;
   logic       auto_rsp = 1'b0;
   int         n_cmp = 0, n_err = 0;
   logic [11:0] sb [$];
   logic [7:0]  pend [$];

   gpu_mem_arbiter_if #(.N_REQ(4), .ADDR_WIDTH(8), .DATA_WIDTH(8)) bus ();
   gpu_mem_arbiter #(.N_REQ(4), .ADDR_WIDTH(8), .DATA_WIDTH(8), .MAX_OUTST(2)) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus), .outstanding(outstanding),
      .busy(busy), .err_unexp(err_unexp)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] memfn(input logic [7:0] a);
      return a + 8'h08;
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      assert (got === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // memory model drives its oldest pending read back when auto_rsp is on
   task automatic settle();
      if (auto_rsp) begin
         bus.m_rsp_vld  = pend.size() > 0;
         bus.m_rsp_data = pend.size() > 0 ? memfn(pend[0]) : 8'h00;
      end
      #1;
   endtask

   task automatic clk_step();
      logic [11:0] e;
      if (bus.m_rsp_vld && bus.m_rsp_rdy) begin
         if (sb.size() == 0) chk("rsp_unexpected", 1, 0);
         else begin
            e = sb.pop_front();
            chk("rsp_owner", {28'h0, bus.r_rsp_vld}, {28'h0, e[11:8]});
            chk("rsp_data", {24'h0, bus.r_rsp_data}, {24'h0, e[7:0]});
         end
         if (pend.size() > 0) void'(pend.pop_front());
      end
      if (bus.m_req_vld && bus.m_req_rdy) pend.push_back(bus.m_req_addr);
      tick();
   endtask

   task automatic grant(input int id);
      logic [7:0] a;
      a = bus.r_req_addr[id*8 +: 8];
      chk($sformatf("gnt%0d_vld", id), {31'h0, bus.m_req_vld}, 1);
      chk($sformatf("gnt%0d_rdy", id), {28'h0, bus.r_req_rdy}, 32'h1 << id);
      chk($sformatf("gnt%0d_addr", id), {24'h0, bus.m_req_addr}, {24'h0, a});
      sb.push_back({4'b0001 << id, memfn(a)});
   endtask

   task automatic drain();
      auto_rsp = 1'b1;
      bus.r_req_vld = 4'b0000;
      repeat (3) begin
         settle();
         clk_step();
      end
      settle();
      chk("drain_outst", {30'h0, outstanding}, 0);
      chk("drain_sb", sb.size(), 0);
   endtask

   initial begin
      bus.r_req_vld  = 4'b1111;
      bus.r_req_addr = {8'h0C, 8'h08, 8'h04, 8'h10};
      bus.r_rsp_rdy  = 4'b1111;
      bus.m_req_rdy  = 1'b1;
      bus.m_rsp_vld  = 1'b0;
      bus.m_rsp_data = 8'h00;
      #2;
      chk("rst_m_req_vld", {31'h0, bus.m_req_vld}, 0);
      chk("rst_r_req_rdy", {28'h0, bus.r_req_rdy}, 0);
      chk("rst_r_rsp_vld", {28'h0, bus.r_rsp_vld}, 0);
      chk("rst_m_rsp_rdy", {31'h0, bus.m_rsp_rdy}, 0);
      chk("rst_outst", {30'h0, outstanding}, 0);
      chk("rst_err", {31'h0, err_unexp}, 0);
      bus.r_req_vld = 4'b0000;
      tick();
      rst_n = 1'b1;
      tick();
      // single requester, 1-cycle memory
      auto_rsp = 1'b1;
      bus.r_req_vld = 4'b0001;
      settle();
      grant(0);
      clk_step();
      bus.r_req_vld = 4'b0000;
      settle();
      chk("t1_outst1", {30'h0, outstanding}, 1);
      chk("t1_no_req", {31'h0, bus.m_req_vld}, 0);
      clk_step();
      settle();
      chk("t1_outst0", {30'h0, outstanding}, 0);
      // all valid: round robin continues from rr_ptr=1
      bus.r_req_addr = {8'h0C, 8'h08, 8'h04, 8'h00};
      bus.r_req_vld = 4'b1111;
      for (int i = 0; i < 8; i++) begin
         settle();
         grant((i + 1) % 4);
         clk_step();
      end
      drain();
      // outstanding limit with memory withholding responses
      auto_rsp = 1'b0;
      bus.m_rsp_vld = 1'b0;
      bus.r_req_vld = 4'b0011;
      settle();
      grant(1);
      clk_step();
      settle();
      grant(0);
      clk_step();
      for (int i = 0; i < 2; i++) begin
         settle();
         chk("t3_full_vld", {31'h0, bus.m_req_vld}, 0);
         chk("t3_full_rdy", {28'h0, bus.r_req_rdy}, 0);
         chk("t3_full_outst", {30'h0, outstanding}, 2);
         clk_step();
      end
      auto_rsp = 1'b1;
      settle();
      chk("t3_pop_no_req", {31'h0, bus.m_req_vld}, 0);
      clk_step();
      settle();
      grant(1);
      clk_step();
      drain();
      // grant lock while memory stalls
      bus.r_req_vld = 4'b0001;
      settle();
      grant(0);
      clk_step();
      drain();
      bus.r_req_vld = 4'b0110;
      bus.m_req_rdy = 1'b0;
      for (int i = 0; i < 3; i++) begin
         settle();
         chk("t4_lock_vld", {31'h0, bus.m_req_vld}, 1);
         chk("t4_lock_addr", {24'h0, bus.m_req_addr}, 32'h04);
         chk("t4_lock_rdy", {28'h0, bus.r_req_rdy}, 0);
         clk_step();
      end
      bus.m_req_rdy = 1'b1;
      settle();
      grant(1);
      clk_step();
      bus.r_req_vld = 4'b0100;
      settle();
      grant(2);
      clk_step();
      drain();
      // response backpressure from owner 2
      bus.r_rsp_rdy = 4'b1011;
      bus.r_req_vld = 4'b0100;
      settle();
      grant(2);
      clk_step();
      bus.r_req_vld = 4'b0001;
      settle();
      chk("t5_m_rsp_rdy", {31'h0, bus.m_rsp_rdy}, 0);
      chk("t5_r_rsp_vld", {28'h0, bus.r_rsp_vld}, 32'b0100);
      grant(0);
      clk_step();
      bus.r_req_vld = 4'b0000;
      settle();
      chk("t5_m_rsp_rdy2", {31'h0, bus.m_rsp_rdy}, 0);
      chk("t5_r_rsp_vld2", {28'h0, bus.r_rsp_vld}, 32'b0100);
      chk("t5_outst", {30'h0, outstanding}, 2);
      clk_step();
      bus.r_rsp_rdy = 4'b1111;
      drain();
      // reset with two requests in flight
      auto_rsp = 1'b0;
      bus.m_rsp_vld = 1'b0;
      bus.r_req_vld = 4'b0011;
      settle();
      grant(1);
      clk_step();
      settle();
      grant(0);
      clk_step();
      chk("t6_outst2", {30'h0, outstanding}, 2);
      rst_n = 1'b0;
      #1;
      chk("t6_outst0", {30'h0, outstanding}, 0);
      chk("t6_m_req_vld", {31'h0, bus.m_req_vld}, 0);
      chk("t6_r_req_rdy", {28'h0, bus.r_req_rdy}, 0);
      chk("t6_m_rsp_rdy", {31'h0, bus.m_rsp_rdy}, 0);
      pend.delete();
      sb.delete();
      tick();
      bus.r_req_vld = 4'b0000;
      rst_n = 1'b1;
      bus.m_rsp_vld = 1'b1;
      #1;
      chk("t6_spur_rdy", {31'h0, bus.m_rsp_rdy}, 0);
      chk("t6_spur_vld", {28'h0, bus.r_rsp_vld}, 0);
      chk("t6_err_before", {31'h0, err_unexp}, 0);
      tick();
      bus.m_rsp_vld = 1'b0;
      chk("t6_err_set", {31'h0, err_unexp}, 1);
      auto_rsp = 1'b1;
      bus.r_req_vld = 4'b1111;
      settle();
      chk("t6_busy", {31'h0, busy}, 1);
      grant(0);
      clk_step();
      drain();
      chk("t6_err_sticky", {31'h0, err_unexp}, 1);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
